// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: requester IDs and the idle ALUOp drive.
// ALUOp encodings themselves stay in the CPU control definitions.
package alu_arbiter_pkg;

   localparam logic       ARB_ID_CPU  = 1'b0;
   localparam logic       ARB_ID_AUX  = 1'b1;
   localparam logic [4:0] ARB_IDLE_OP = 5'd0;

endpackage

// File: rtl/alu_arb_pick.sv
// Combinational two-way grant. Policy is set by macro ALU_ARB_RR_EN:
// defined -> round-robin on conflict, undefined -> requester 0 always wins.
module alu_arb_pick
   import alu_arbiter_pkg::*;
(
   input  logic v0,
   input  logic v1,
`ifdef ALU_ARB_RR_EN
   input  logic last,
`endif
   output logic grant0,
   output logic grant1
);

`ifdef ALU_ARB_RR_EN
   // On conflict the requester that was not served last wins.
   assign grant0 = v0 & (~v1 | (last == ARB_ID_AUX));
   assign grant1 = v1 & (~v0 | (last == ARB_ID_CPU));
`else
   assign grant0 = v0;
   assign grant1 = v1 & ~v0;
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between the CPU (req0) and an auxiliary
// unit (req1) via an issue register and a tagged response register. Macro: ALU_ARB_RR_EN.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int DW  = 32,
   parameter int OPW = 5
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [OPW-1:0] req0_op,
   input  logic [DW-1:0]  req0_a,
   input  logic [DW-1:0]  req0_b,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [OPW-1:0] req1_op,
   input  logic [DW-1:0]  req1_a,
   input  logic [DW-1:0]  req1_b,
   output logic [DW-1:0]  alu_a,
   output logic [DW-1:0]  alu_b,
   output logic [OPW-1:0] alu_op,
   input  logic [DW-1:0]  alu_c,
   input  logic           alu_zero,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic           rsp_id,
   output logic [DW-1:0]  rsp_c,
   output logic           rsp_zero
);

   // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
   // valid never depends on ready, and ready reaches back from rsp_ready only via iss_move.
   logic           iss_valid;
   logic           iss_id;
   logic [OPW-1:0] iss_op;
   logic [DW-1:0]  iss_a;
   logic [DW-1:0]  iss_b;

   logic grant0, grant1;
   logic iss_move, iss_free;
   logic acc0, acc1, acc;

`ifdef ALU_ARB_RR_EN
   logic last;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         last <= ARB_ID_AUX;
      else if (acc)
         last <= acc1 ? ARB_ID_AUX : ARB_ID_CPU;
   end

   alu_arb_pick u_pick (
      .v0     (req0_valid),
      .v1     (req1_valid),
      .last   (last),
      .grant0 (grant0),
      .grant1 (grant1)
   );
`else
   alu_arb_pick u_pick (
      .v0     (req0_valid),
      .v1     (req1_valid),
      .grant0 (grant0),
      .grant1 (grant1)
   );
`endif

   assign iss_move = iss_valid & (~rsp_valid | rsp_ready);
   assign iss_free = ~iss_valid | iss_move;

   // rstn gating keeps both readies low for the whole time reset is asserted.
   assign req0_ready = grant0 & iss_free & rstn;
   assign req1_ready = grant1 & iss_free & rstn;

   assign acc0 = req0_valid & req0_ready;
   assign acc1 = req1_valid & req1_ready;
   assign acc  = acc0 | acc1;

   assign alu_a  = iss_valid ? iss_a  : '0;
   assign alu_b  = iss_valid ? iss_b  : '0;
   assign alu_op = iss_valid ? iss_op : OPW'(ARB_IDLE_OP);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         iss_valid <= 1'b0;
         iss_id    <= ARB_ID_CPU;
         iss_op    <= '0;
         iss_a     <= '0;
         iss_b     <= '0;
      end else if (acc) begin
         iss_valid <= 1'b1;
         iss_id    <= acc1 ? ARB_ID_AUX : ARB_ID_CPU;
         iss_op    <= acc1 ? req1_op : req0_op;
         iss_a     <= acc1 ? req1_a  : req0_a;
         iss_b     <= acc1 ? req1_b  : req0_b;
      end else if (iss_move) begin
         iss_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rsp_valid <= 1'b0;
         rsp_id    <= ARB_ID_CPU;
         rsp_c     <= '0;
         rsp_zero  <= 1'b0;
      end else if (iss_move) begin
         rsp_valid <= 1'b1;
         rsp_id    <= iss_id;
         rsp_c     <= alu_c;
         rsp_zero  <= alu_zero;
      end else if (rsp_valid && rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule
